// File: rtl/data_memory_dbg.sv
// data_memory_dbg: parametrised data memory for the BIP datapath.
// All state (registers and the memory array) updates on the falling edge of clk.
//
// Features:
//   - A clear sequencer zeroes every word, one word per edge. It starts after
//     reset (when INIT_ON_RESET=1) or on a clear_req pulse.
//   - A registered debug read port, used by the debug unit for memory dumps.
//   - Detection of out-of-range CPU addresses.
//
// Ports:
//   clk        clock; all updates happen on its falling edge
//   reset      synchronous active-high reset, sampled on the falling edge
//   WrRd       CPU operation: 2'b10 write, 2'b01 read, 2'b00/2'b11 no-op
//   addr       CPU word address
//   inData     CPU write data
//   outData    CPU read data (registered)
//   clear_req  single-cycle request to zero the whole memory
//   busy       high while the clear sequence runs
//   addr_err   one-edge pulse on an out-of-range CPU read or write
//   dbg_addr   debug read address
//   dbg_data   debug read data (registered)
module data_memory_dbg #(
  parameter int ADDR_LENGTH   = 11,
  parameter int DATA_LENGTH   = 16,
  parameter int MEM_DEPTH     = 2**ADDR_LENGTH,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             WrRd,
  input  logic [ADDR_LENGTH-1:0] addr,
  input  logic [DATA_LENGTH-1:0] inData,
  output logic [DATA_LENGTH-1:0] outData,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   addr_err,
  input  logic [ADDR_LENGTH-1:0] dbg_addr,
  output logic [DATA_LENGTH-1:0] dbg_data
);

  // Width of an index into the implemented words (never wider than addr).
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // The counter is one bit wider than the address bus, so that
  // MEM_DEPTH = 2**ADDR_LENGTH can be represented and terminates correctly.
  localparam logic [ADDR_LENGTH:0] DEPTH_W = (ADDR_LENGTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_LENGTH:0] LAST_W  = (ADDR_LENGTH+1)'(MEM_DEPTH - 1);
  localparam logic [ADDR_LENGTH:0] ONE_W   = (ADDR_LENGTH+1)'(1);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_LENGTH:0]   cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] out_q, out_d;
  logic [DATA_LENGTH-1:0] dbg_q, dbg_d;
  logic                   err_q, err_d;

  logic [DATA_LENGTH-1:0] mem [MEM_DEPTH];
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [DATA_LENGTH-1:0] mem_wdata;

  // Addresses are compared unsigned, against the implemented depth.
  function automatic logic in_range(input logic [ADDR_LENGTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr[IDX_W-1:0];
    mem_wdata = inData;
    // The debug port reads the array before this edge's write lands, so a
    // collision with a CPU write or a clear write returns the old word.
    dbg_d     = in_range(dbg_addr) ? mem[dbg_addr[IDX_W-1:0]] : '0;

    if (reset) begin
      out_d   = '0;
      dbg_d   = '0;
      cnt_d   = '0;
      state_d = INIT_ON_RESET ? CLEAR : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            // Starting a clear takes precedence; this edge's CPU op is dropped.
            state_d = CLEAR;
            cnt_d   = '0;
          end else if (WrRd == OP_READ) begin
            if (in_range(addr)) begin
              out_d = mem[addr[IDX_W-1:0]];
            end else begin
              out_d = '0;
              err_d = 1'b1;
            end
          end else if (WrRd == OP_WRITE) begin
            if (in_range(addr)) begin
              mem_we = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CLEAR: begin
          // The CPU port is ignored here; clear_req does not restart the sweep.
          mem_we    = 1'b1;
          mem_waddr = cnt_q[IDX_W-1:0];
          mem_wdata = '0;
          if (cnt_q == LAST_W) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE_W;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    out_q   <= out_d;
    dbg_q   <= dbg_d;
    err_q   <= err_d;
  end

  // The memory array itself is never reset; only the clear sweep zeroes it.
  always_ff @(negedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign outData  = out_q;
  assign dbg_data = dbg_q;
  assign addr_err = err_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_data_memory_dbg.sv
module tb_data_memory_dbg;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: depth 12, cleared on reset
  logic          a_reset = 1'b1, a_clr = 1'b0;
  logic [1:0]    a_wrrd = 2'b00;
  logic [AW-1:0] a_addr = '0, a_dbg_addr = 4'd12;
  logic [DW-1:0] a_in = '0, a_out, a_dbg;
  logic          a_busy, a_err;

  // DUT B: depth 16, memory kept across reset
  logic          b_reset = 1'b1, b_clr = 1'b0;
  logic [1:0]    b_wrrd = 2'b00;
  logic [AW-1:0] b_addr = '0, b_dbg_addr = '0;
  logic [DW-1:0] b_in = '0, b_out, b_dbg;
  logic          b_busy, b_err;

  data_memory_dbg #(.ADDR_LENGTH(AW), .DATA_LENGTH(DW), .MEM_DEPTH(DEPTH),
                    .INIT_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(a_reset), .WrRd(a_wrrd), .addr(a_addr), .inData(a_in),
    .outData(a_out), .clear_req(a_clr), .busy(a_busy), .addr_err(a_err),
    .dbg_addr(a_dbg_addr), .dbg_data(a_dbg));

  data_memory_dbg #(.ADDR_LENGTH(AW), .DATA_LENGTH(DW), .MEM_DEPTH(16),
                    .INIT_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(b_reset), .WrRd(b_wrrd), .addr(b_addr), .inData(b_in),
    .outData(b_out), .clear_req(b_clr), .busy(b_busy), .addr_err(b_err),
    .dbg_addr(b_dbg_addr), .dbg_data(b_dbg));

  int errors = 0;
  int checks = 0;

  // Reference model of DUT A: a plain word array plus a "clearing" flag and
  // the index of the next word to be zeroed.
  int unsigned m_mem [DEPTH];
  int unsigned m_out = 0, m_dbg = 0;
  bit          m_err = 0, m_clearing = 0;
  int          m_next = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one falling edge, using the inputs currently driven.
  task automatic model_step();
    int unsigned snap [DEPTH];
    snap = m_mem;
    m_err = 0;
    if (a_reset) begin
      m_out = 0;
      m_dbg = 0;
      m_next = 0;
      m_clearing = 1;
    end else begin
      m_dbg = (int'(a_dbg_addr) < DEPTH) ? snap[a_dbg_addr] : 0;
      if (m_clearing) begin
        m_mem[m_next] = 0;
        m_next++;
        if (m_next == DEPTH) begin
          m_clearing = 0;
          m_next = 0;
        end
      end else if (a_clr) begin
        m_clearing = 1;
        m_next = 0;
      end else if (a_wrrd == 2'b01) begin
        if (int'(a_addr) < DEPTH) m_out = snap[a_addr];
        else begin m_out = 0; m_err = 1; end
      end else if (a_wrrd == 2'b10) begin
        if (int'(a_addr) < DEPTH) m_mem[a_addr] = a_in;
        else m_err = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
    check("a_outData", a_out, m_out);
    check("a_dbg_data", a_dbg, m_dbg);
    check("a_busy", a_busy, m_clearing);
    check("a_addr_err", a_err, m_err);
  endtask

  task automatic a_op(input logic [1:0] op, input int ad, input logic [DW-1:0] d);
    a_wrrd = op;
    a_addr = AW'(ad);
    a_in   = d;
    tick();
    a_wrrd = 2'b00;
  endtask

  // Run ticks until busy drops, returning how many ticks it took.
  task automatic count_busy(output int n);
    n = 0;
    while (a_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;

    // 1: reset for two edges, then the 12-edge clear
    tick();
    check("b_busy_after_reset", b_busy, 1'b0);
    check("b_outData_after_reset", b_out, 16'h0000);
    check("b_addr_err_after_reset", b_err, 1'b0);
    tick();
    check("a_busy_during_reset", a_busy, 1'b1);
    a_reset = 1'b0;
    b_reset = 1'b0;
    count_busy(n);
    check("clear_len_after_reset", n, 12);
    for (int i = 0; i < DEPTH; i++) begin
      a_dbg_addr = AW'(i);
      tick();
      check("dbg_after_clear", a_dbg, 16'h0000);
    end

    // 2: write/read, no-op hold, WrRd=11 stores nothing
    a_op(2'b10, 5, 16'hBEEF);
    a_op(2'b01, 5, 16'h0000);
    check("read_beef", a_out, 16'hBEEF);
    a_op(2'b00, 5, 16'h1111);
    check("noop_holds", a_out, 16'hBEEF);
    a_op(2'b11, 5, 16'h2222);
    a_op(2'b01, 5, 16'h0000);
    check("op11_no_write", a_out, 16'hBEEF);

    // 3: out-of-range write and read
    a_op(2'b10, 12, 16'h1234);
    check("oor_write_err", a_err, 1'b1);
    tick();
    check("oor_err_drops", a_err, 1'b0);
    a_op(2'b01, 12, 16'h0000);
    check("oor_read_err", a_err, 1'b1);
    check("oor_read_zero", a_out, 16'h0000);
    a_dbg_addr = 4'd12;
    tick();
    check("dbg_oor_zero", a_dbg, 16'h0000);
    check("dbg_oor_no_err", a_err, 1'b0);
    a_op(2'b01, 11, 16'h0000);
    check("addr11_untouched", a_out, 16'h0000);

    // 4: read-first collision between CPU write and debug read
    a_op(2'b10, 3, 16'h5555);
    a_dbg_addr = 4'd3;
    a_op(2'b10, 3, 16'hAAAA);
    check("rdw_old_word", a_dbg, 16'h5555);
    tick();
    check("rdw_new_word", a_dbg, 16'hAAAA);

    // 5: fill, clear, reset mid-clear restarts the sweep
    for (int i = 0; i < DEPTH; i++) a_op(2'b10, i, 16'h00FF);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("clear_req_busy", a_busy, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    a_wrrd = 2'b10; a_addr = 4'd7; a_in = 16'h7777;
    tick();
    a_wrrd = 2'b00;
    a_clr = 1'b1;  // ignored while clearing
    tick();
    a_clr = 1'b0;
    count_busy(n);
    check("clear_restart_len", n + 2, 12);
    for (int i = 0; i < DEPTH; i++) begin
      a_op(2'b01, i, 16'h0000);
      check("word_cleared", a_out, 16'h0000);
    end

    // 6: memory kept across reset when INIT_ON_RESET=0
    b_wrrd = 2'b10; b_addr = 4'd15; b_in = 16'hCAFE;
    tick();
    b_wrrd = 2'b00; b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    check("b_busy_stays_low", b_busy, 1'b0);
    check("b_out_reset", b_out, 16'h0000);
    b_wrrd = 2'b01; b_addr = 4'd15;
    tick();
    b_wrrd = 2'b00;
    check("b_read_cafe", b_out, 16'hCAFE);
    check("b_no_err", b_err, 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      a_wrrd     = 2'($urandom_range(0, 3));
      a_addr     = AW'($urandom_range(0, 15));
      a_in       = DW'($urandom);
      a_dbg_addr = AW'($urandom_range(0, 15));
      a_clr      = ($urandom_range(0, 39) == 0);
      a_reset    = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
